cutoff_glide: RTL

CUTOFF_GLIDE -- requirements
Module: cutoff_glide

---
 rtl/cutoff_glide.sv | 80 ++++++++
 1 files changed

// File: rtl/cutoff_glide.sv
// rtl/cutoff_glide.sv - slews a filter cutoff coefficient toward a requested target once per audio tick.
// Optional target clamping to [K_MIN, K_MAX] is compiled in with CUTOFF_GLIDE_LIMIT_EN.
module cutoff_glide #(
   parameter logic [17:0] K_RESET = 18'h00800,
   parameter logic [17:0] K_MIN   = 18'h00040,
   parameter logic [17:0] K_MAX   = 18'h3F000
) (
   input  logic        clk_fast,
   input  logic        rst_b,
   input  logic        sample_tick,
   input  logic [17:0] target_k,
   input  logic        target_valid,
   output logic        target_ready,
   input  logic [11:0] step,
   output logic [17:0] k_fixed,
   output logic        k_update,
   output logic        at_target
);

   typedef enum logic {IDLE, GLIDE} state_t;

   state_t      state;
   logic [17:0] target;
   logic [17:0] eff_target;
   logic [17:0] next_target;
   logic [17:0] next_k;
   logic [18:0] step_w;
   logic [18:0] diff_up;
   logic [18:0] diff_down;

   assign target_ready = 1'b1;

`ifdef CUTOFF_GLIDE_LIMIT_EN
   always_comb begin
      eff_target = target_k;
      if (target_k < K_MIN)
         eff_target = K_MIN;
      else if (target_k > K_MAX)
         eff_target = K_MAX;
   end
`else
   logic unused_limits;
   assign unused_limits = ^{K_MIN, K_MAX};
   always_comb eff_target = target_k;
`endif

   // The step always uses the target latched before this edge; a new offer applies from the next tick.
   always_comb begin
      step_w    = {7'd0, step};
      diff_up   = {1'b0, target} - {1'b0, k_fixed};
      diff_down = {1'b0, k_fixed} - {1'b0, target};
      next_k    = k_fixed;
      if (state == GLIDE && sample_tick) begin
         if (target > k_fixed)
            next_k = (step == 12'd0 || diff_up <= step_w) ? target
                                                         : 18'({1'b0, k_fixed} + step_w);
         else if (target < k_fixed)
            next_k = (step == 12'd0 || diff_down <= step_w) ? target
                                                           : 18'({1'b0, k_fixed} - step_w);
      end
      next_target = target_valid ? eff_target : target;
   end

   always_ff @(posedge clk_fast or negedge rst_b) begin
      if (!rst_b) begin
         state    <= IDLE;
         k_fixed  <= K_RESET;
         target   <= K_RESET;
         k_update <= 1'b0;
      end else begin
         k_fixed  <= next_k;
         target   <= next_target;
         k_update <= (next_k != k_fixed);
         state    <= (next_target != next_k) ? GLIDE : IDLE;
      end
   end

   assign at_target = (state == IDLE) && (k_fixed == target);

endmodule
